// File: rtl/cpu_fpu_int.sv
// Multi-cycle binary32 to int32/uint32 converter (FCVT.W.S / FCVT.WU.S).
// Aligns the significand one bit per cycle, rounds per RISC-V mode, then range-checks.
module cpu_fpu_int (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic [31:0] i_op1,
  input  logic        i_signed,
  input  logic [2:0]  i_rm,
  output logic        o_ready,
  output logic [31:0] o_result,
  output logic        o_invalid,
  output logic        o_inexact
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_ROUND = 3'd2,
    S_PACK  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [63:0]        r_q, r_d;
  logic               sticky_q, sticky_d;
  logic signed [6:0]  exp_q, exp_d;
  logic               sign_q, sign_d;
  logic               sgn_op_q, sgn_op_d;
  logic [2:0]         rm_q, rm_d;
  logic               sat_q, sat_d;
  logic [32:0]        mag_q, mag_d;
  logic               nx_q, nx_d;
  logic               ready_q, ready_d;
  logic [31:0]        result_q, result_d;
  logic               invalid_q, invalid_d;
  logic               inexact_q, inexact_d;

  logic [7:0]         op_exp_s;
  logic [22:0]        op_frac_s;
  logic [23:0]        op_man_s;
  logic signed [8:0]  unb_s;
  logic [31:0]        q_s;
  logic               g_s;
  logic               st_s;
  logic               inc_s;
  logic               range_bad_s;
  logic               bad_s;
  logic [31:0]        sat_val_s;

  assign op_exp_s  = i_op1[30:23];
  assign op_frac_s = i_op1[22:0];
  assign op_man_s  = {(op_exp_s != 8'd0), op_frac_s};
  assign unb_s     = $signed({1'b0, op_exp_s}) - 9'sd127;

  assign q_s  = r_q[63:32];
  assign g_s  = r_q[31];
  assign st_s = (|r_q[30:0]) | sticky_q;

  // Rounding increment decision for the captured mode
  always_comb begin
    inc_s = 1'b0;
    case (rm_q)
      3'd1:    inc_s = 1'b0;
      3'd2:    inc_s = sign_q & (g_s | st_s);
      3'd3:    inc_s = ~sign_q & (g_s | st_s);
      3'd4:    inc_s = g_s;
      default: inc_s = g_s & (st_s | q_s[0]);
    endcase
  end

  // Range check of the rounded magnitude and the saturation value
  always_comb begin
    range_bad_s = 1'b0;
    if (sgn_op_q) begin
      if (sign_q) begin
        range_bad_s = (mag_q > 33'h0_8000_0000);
      end else begin
        range_bad_s = (mag_q > 33'h0_7FFF_FFFF);
      end
      sat_val_s = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      if (sign_q) begin
        range_bad_s = (mag_q != 33'd0);
      end else begin
        range_bad_s = (mag_q > 33'h0_FFFF_FFFF);
      end
      sat_val_s = sign_q ? 32'h0000_0000 : 32'hFFFF_FFFF;
    end
    bad_s = sat_q | range_bad_s;
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    sticky_d  = sticky_q;
    exp_d     = exp_q;
    sign_d    = sign_q;
    sgn_op_d  = sgn_op_q;
    rm_d      = rm_q;
    sat_d     = sat_q;
    mag_d     = mag_q;
    nx_d      = nx_q;
    ready_d   = ready_q;
    result_d  = result_q;
    invalid_d = invalid_q;
    inexact_d = inexact_q;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b0;
        if (i_request) begin
          sgn_op_d = i_signed;
          rm_d     = i_rm;
          sign_d   = i_op1[31];
          sat_d    = 1'b0;
          sticky_d = 1'b0;
          nx_d     = 1'b0;
          mag_d    = 33'd0;
          r_d      = 64'd0;
          if (op_exp_s == 8'hFF || unb_s >= 9'sd32) begin
            // NaN saturates as if positive
            sat_d   = 1'b1;
            sign_d  = i_op1[31] & ~((op_exp_s == 8'hFF) && (op_frac_s != 23'd0));
            state_d = S_PACK;
          end else if (op_exp_s == 8'd0 && op_frac_s == 23'd0) begin
            state_d = S_PACK;
          end else if (unb_s <= -9'sd33) begin
            sticky_d = |op_man_s;
            state_d  = S_ROUND;
          end else begin
            r_d     = {31'd0, op_man_s, 9'd0};
            exp_d   = unb_s[6:0];
            state_d = (unb_s == 9'sd0) ? S_ROUND : S_SHIFT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (exp_q > 7'sd0) begin
          r_d   = r_q << 1;
          exp_d = exp_q - 7'sd1;
        end else begin
          r_d      = r_q >> 1;
          sticky_d = sticky_q | r_q[0];
          exp_d    = exp_q + 7'sd1;
        end
        if (exp_q == 7'sd1 || exp_q == -7'sd1) begin
          state_d = S_ROUND;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_ROUND: begin
        mag_d   = {1'b0, q_s} + {32'd0, inc_s};
        nx_d    = g_s | st_s;
        state_d = S_PACK;
      end
      S_PACK: begin
        invalid_d = bad_s;
        if (bad_s) begin
          result_d  = sat_val_s;
          inexact_d = 1'b0;
        end else begin
          result_d  = (sgn_op_q && sign_q) ? (32'd0 - mag_q[31:0]) : mag_q[31:0];
          inexact_d = nx_q;
        end
        ready_d = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        // Present the result for at least one cycle, then wait for request low
        if (!ready_q) begin
          ready_d = 1'b1;
          state_d = S_DONE;
        end else if (!i_request) begin
          ready_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        ready_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= S_IDLE;
      r_q       <= 64'd0;
      sticky_q  <= 1'b0;
      exp_q     <= 7'sd0;
      sign_q    <= 1'b0;
      sgn_op_q  <= 1'b0;
      rm_q      <= 3'd0;
      sat_q     <= 1'b0;
      mag_q     <= 33'd0;
      nx_q      <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= 32'd0;
      invalid_q <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      sticky_q  <= sticky_d;
      exp_q     <= exp_d;
      sign_q    <= sign_d;
      sgn_op_q  <= sgn_op_d;
      rm_q      <= rm_d;
      sat_q     <= sat_d;
      mag_q     <= mag_d;
      nx_q      <= nx_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
      invalid_q <= invalid_d;
      inexact_q <= inexact_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_result  = result_q;
  assign o_invalid = invalid_q;
  assign o_inexact = inexact_q;

endmodule

// File: tb/tb_cpu_fpu_int.sv
// Self-checking bench for cpu_fpu_int: directed spec vectors, reset cases,
// held-request behaviour and randomized operands against an arithmetic model.
module tb_cpu_fpu_int;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] op = 32'd0;
  logic        sg = 1'b0;
  logic [2:0]  rm = 3'd0;
  logic        rdy;
  logic [31:0] res;
  logic        inv;
  logic        nx;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] a;
    logic        s;
    logic [2:0]  m;
    logic [31:0] r;
    logic        i;
    logic        x;
    int          l;
  } vec_t;

  always #5 clk = ~clk;

  cpu_fpu_int dut (
    .i_clock   (clk),
    .i_reset   (rst_n),
    .i_request (req),
    .i_op1     (op),
    .i_signed  (sg),
    .i_rm      (rm),
    .o_ready   (rdy),
    .o_result  (res),
    .o_invalid (inv),
    .o_inexact (nx)
  );

  // Exact value = m * 2^(E-23); integer part and fraction as 64.64 fixed point.
  function automatic void ref_conv(input logic [31:0] a, input logic s_in, input logic [2:0] m_in,
                                   output logic [31:0] r, output logic i, output logic x, output int lat);
    logic        s;
    int          ex;
    int          e_unb;
    logic [22:0] fr;
    logic [23:0] man;
    logic [127:0] fx;
    logic [63:0] frac;
    logic [63:0] half;
    longint      mag;
    longint      v;
    bit          up;
    bit          ok;
    bit          nan;
    bit          neg;
    s = a[31];
    ex = int'(a[30:23]);
    fr = a[22:0];
    e_unb = ex - 127;
    half = 64'h8000_0000_0000_0000;
    r = 32'd0; i = 1'b0; x = 1'b0;
    if (e_unb >= 32) begin
      nan = (ex == 255) && (fr != 23'd0);
      neg = s && !nan;
      i = 1'b1;
      r = s_in ? (neg ? 32'h8000_0000 : 32'h7FFF_FFFF) : (neg ? 32'h0 : 32'hFFFF_FFFF);
      lat = 2;
      return;
    end
    if (ex == 0 && fr == 23'd0) begin
      lat = 2;
      return;
    end
    lat = (e_unb <= -33) ? 3 : ((e_unb < 0 ? -e_unb : e_unb) + 3);
    man = {(ex != 0), fr};
    if (e_unb < -41) begin
      mag = 64'sd0;
      frac = 64'd1;
    end else begin
      fx = 128'(man) << (41 + e_unb);
      mag = $signed(fx[127:64]);
      frac = fx[63:0];
    end
    case (m_in)
      3'd1:    up = 1'b0;
      3'd2:    up = s && (frac != 64'd0);
      3'd3:    up = !s && (frac != 64'd0);
      3'd4:    up = (frac >= half);
      default: up = (frac > half) || ((frac == half) && mag[0]);
    endcase
    if (up) mag = mag + 64'sd1;
    v = s ? -mag : mag;
    if (s_in) ok = (v >= -64'sd2147483648) && (v <= 64'sd2147483647);
    else      ok = (v >= 64'sd0) && (v <= 64'sd4294967295);
    if (ok) begin
      r = v[31:0];
      x = (frac != 64'd0);
    end else begin
      i = 1'b1;
      r = s_in ? (s ? 32'h8000_0000 : 32'h7FFF_FFFF) : (s ? 32'h0 : 32'hFFFF_FFFF);
    end
  endfunction

  // Issue one request, scramble inputs after capture, count edges until ready
  task automatic do_conv(input logic [31:0] a, input logic s_in, input logic [2:0] m_in,
                         output logic [31:0] r_out, output logic i_out, output logic x_out,
                         output int lat);
    @(negedge clk);
    op = a; sg = s_in; rm = m_in; req = 1'b1;
    @(posedge clk);
    #1;
    op = $urandom; sg = ~s_in; rm = 3'($urandom_range(0, 7));
    lat = 0;
    while (lat < 60) begin
      @(posedge clk);
      lat++;
      #1;
      if (rdy) break;
    end
    r_out = res; i_out = inv; x_out = nx;
  endtask

  task automatic drop_req(output logic rdy_after);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #1;
    rdy_after = rdy;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({rdy, inv, nx, res} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b inv=%b nx=%b res=%h, want all zero", rdy, inv, nx, res);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (rdy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got rdy=%b want 0", rdy);
    end
  endtask

  task automatic test_directed;
    vec_t tbl[$];
    logic [31:0] r; logic i; logic x; logic ra; int lat;
    tbl.push_back('{32'h3F800000, 1'b1, 3'd0, 32'h00000001, 1'b0, 1'b0, 3});
    tbl.push_back('{32'h40200000, 1'b1, 3'd0, 32'h00000002, 1'b0, 1'b1, 4});
    tbl.push_back('{32'h40200000, 1'b1, 3'd4, 32'h00000003, 1'b0, 1'b1, 4});
    tbl.push_back('{32'h40200000, 1'b1, 3'd3, 32'h00000003, 1'b0, 1'b1, 4});
    tbl.push_back('{32'h40200000, 1'b1, 3'd1, 32'h00000002, 1'b0, 1'b1, 4});
    tbl.push_back('{32'h40200000, 1'b1, 3'd7, 32'h00000002, 1'b0, 1'b1, 4});
    tbl.push_back('{32'hBFC00000, 1'b1, 3'd2, 32'hFFFFFFFE, 1'b0, 1'b1, 3});
    tbl.push_back('{32'hBFC00000, 1'b1, 3'd1, 32'hFFFFFFFF, 1'b0, 1'b1, 3});
    tbl.push_back('{32'h4F000000, 1'b1, 3'd0, 32'h7FFFFFFF, 1'b1, 1'b0, 34});
    tbl.push_back('{32'h4F000000, 1'b0, 3'd0, 32'h80000000, 1'b0, 1'b0, 34});
    tbl.push_back('{32'hBF000000, 1'b0, 3'd1, 32'h00000000, 1'b0, 1'b1, 4});
    tbl.push_back('{32'hBF800000, 1'b0, 3'd0, 32'h00000000, 1'b1, 1'b0, 3});
    tbl.push_back('{32'h7FC00000, 1'b0, 3'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 2});
    tbl.push_back('{32'h7FC00000, 1'b1, 3'd0, 32'h7FFFFFFF, 1'b1, 1'b0, 2});
    tbl.push_back('{32'hCF000000, 1'b1, 3'd0, 32'h80000000, 1'b0, 1'b0, 34});
    tbl.push_back('{32'hCF000001, 1'b1, 3'd0, 32'h80000000, 1'b1, 1'b0, 34});
    tbl.push_back('{32'hFF800000, 1'b1, 3'd0, 32'h80000000, 1'b1, 1'b0, 2});
    tbl.push_back('{32'h80000000, 1'b1, 3'd3, 32'h00000000, 1'b0, 1'b0, 2});
    tbl.push_back('{32'h4F800000, 1'b0, 3'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 2});
    tbl.push_back('{32'h4F7FFFFF, 1'b0, 3'd0, 32'hFFFFFF00, 1'b0, 1'b0, 34});
    tbl.push_back('{32'h2F800000, 1'b0, 3'd3, 32'h00000001, 1'b0, 1'b1, 35});
    tbl.push_back('{32'h2F000000, 1'b0, 3'd3, 32'h00000001, 1'b0, 1'b1, 3});
    tbl.push_back('{32'h3F000000, 1'b1, 3'd0, 32'h00000000, 1'b0, 1'b1, 4});
    tbl.push_back('{32'h3FC00000, 1'b1, 3'd0, 32'h00000002, 1'b0, 1'b1, 3});
    foreach (tbl[k]) begin
      do_conv(tbl[k].a, tbl[k].s, tbl[k].m, r, i, x, lat);
      n_vec++;
      if ({r, i, x} !== {tbl[k].r, tbl[k].i, tbl[k].x}) begin
        n_err++;
        $display("FAIL directed[%0d] op=%h: got res=%h nv=%b nx=%b, want res=%h nv=%b nx=%b",
                 k, tbl[k].a, r, i, x, tbl[k].r, tbl[k].i, tbl[k].x);
      end
      n_vec++;
      if (lat !== tbl[k].l) begin
        n_err++;
        $display("FAIL directed_latency[%0d] op=%h: got %0d edges, want %0d", k, tbl[k].a, lat, tbl[k].l);
      end
      drop_req(ra);
      n_vec++;
      if (ra !== 1'b0) begin
        n_err++;
        $display("FAIL directed_release[%0d]: got rdy=%b want 0", k, ra);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r; logic i; logic x; logic ra; int lat;
    do_conv(32'h40200000, 1'b1, 3'd0, r, i, x, lat);
    for (int c = 0; c < 5; c++) begin
      op = 32'h3F800000; sg = 1'b1; rm = 3'd0;
      @(posedge clk);
      #1;
      n_vec++;
      if ({rdy, res, inv, nx} !== {1'b1, 32'h2, 1'b0, 1'b1}) begin
        n_err++;
        $display("FAIL held_request[%0d]: got rdy=%b res=%h nv=%b nx=%b, want rdy=1 res=00000002 nv=0 nx=1",
                 c, rdy, res, inv, nx);
      end
    end
    drop_req(ra);
    n_vec++;
    if (ra !== 1'b0) begin
      n_err++;
      $display("FAIL held_release: got rdy=%b want 0", ra);
    end
    do_conv(32'h3F800000, 1'b1, 3'd0, r, i, x, lat);
    n_vec++;
    if ({r, i, x, lat} !== {32'h1, 1'b0, 1'b0, 32'd3}) begin
      n_err++;
      $display("FAIL back_to_back: got res=%h nv=%b nx=%b lat=%0d, want 00000001 0 0 3", r, i, x, lat);
    end
    drop_req(ra);
  endtask

  task automatic test_reset_mid_shift;
    logic [31:0] r; logic i; logic x; logic ra; int lat;
    @(negedge clk);
    op = 32'h4E800000; sg = 1'b1; rm = 3'd0; req = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({rdy, inv, nx, res} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_mid_shift: got rdy=%b nv=%b nx=%b res=%h, want all zero", rdy, inv, nx, res);
    end
    req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_conv(32'h4E800000, 1'b1, 3'd0, r, i, x, lat);
    n_vec++;
    if ({r, i, x} !== {32'h40000000, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL after_reset_conv: got res=%h nv=%b nx=%b, want 40000000 0 0", r, i, x);
    end
    n_vec++;
    if (lat !== 33) begin
      n_err++;
      $display("FAIL after_reset_latency: got %0d want 33", lat);
    end
    drop_req(ra);
  endtask

  task automatic test_random;
    logic [31:0] a; logic [7:0] e; logic [22:0] f; logic s_in; logic [2:0] m_in;
    logic [31:0] r; logic i; logic x; logic ra; int lat;
    logic [31:0] er; logic ei; logic ex; int el;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       e = 8'hFF;
        1:       e = 8'($urandom_range(0, 3));
        2:       e = 8'($urandom_range(60, 95));
        default: e = 8'($urandom_range(96, 160));
      endcase
      f = 23'($urandom);
      if ($urandom_range(0, 2) == 0) f = f & 23'h7C0000;
      if ($urandom_range(0, 15) == 0) f = 23'd0;
      a = {1'($urandom), e, f};
      s_in = 1'($urandom);
      m_in = 3'($urandom_range(0, 7));
      ref_conv(a, s_in, m_in, er, ei, ex, el);
      do_conv(a, s_in, m_in, r, i, x, lat);
      n_vec++;
      if ({r, i, x} !== {er, ei, ex}) begin
        n_err++;
        $display("FAIL random[%0d] op=%h signed=%b rm=%0d: got res=%h nv=%b nx=%b, want res=%h nv=%b nx=%b",
                 n, a, s_in, m_in, r, i, x, er, ei, ex);
      end
      n_vec++;
      if (lat !== el) begin
        n_err++;
        $display("FAIL random_latency[%0d] op=%h: got %0d want %0d", n, a, lat, el);
      end
      drop_req(ra);
      n_vec++;
      if (ra !== 1'b0) begin
        n_err++;
        $display("FAIL random_release[%0d]: got rdy=%b want 0", n, ra);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_reset_mid_shift;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
